// File: rtl/byte_mux_rr_arbiter.sv
// Round-robin arbiter for an 8-way byte mux with a registered valid/ready output stage.
// One winner per transfer; the winner gets a one-cycle ack when its byte is captured.
module byte_mux_rr_arbiter #(
    parameter int DW = 8,
    parameter int N  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] data_flat,
    output logic [N-1:0]    ack,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_sel,
    output logic            busy
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      sel_q, sel_d;
    logic [DW-1:0]   data_q, data_d;
    logic [N-1:0]    ack_q, ack_d;

    logic [DW-1:0]   bytes [N];
    logic [N-1:0]    eligible;
    logic            found;
    logic [2:0]      win;
    logic [2:0]      idx;
    logic            load;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_split
            assign bytes[gi] = data_flat[gi*DW +: DW];
        end
    endgenerate

    // A requester acked this cycle is still showing the byte just taken; mask it.
    assign eligible = req & ~ack_q;
    assign load     = (state_q == IDLE) || out_ready;

    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        idx   = 3'd0;
        for (int k = 1; k <= N; k++) begin
            idx = ptr_q + k[2:0];
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        ack_d   = '0;
        if (load) begin
            if (found) begin
                state_d    = HOLD;
                ptr_d      = win;
                sel_d      = win;
                data_d     = bytes[win];
                ack_d[win] = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd7;
            sel_q   <= 3'd0;
            data_q  <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    assign ack       = ack_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == HOLD);

endmodule

// File: tb/tb_byte_mux_rr_arbiter.sv
// Directed bench for byte_mux_rr_arbiter: one task per scenario, inline compares,
// outputs sampled 1ns after the rising edge, inputs driven right after sampling.
module tb_byte_mux_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req;
    logic [63:0] data_flat;
    logic [7:0]  ack;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_sel;
    logic        busy;

    int n_cmp;
    int n_bad;
    logic [7:0] exp_byte [8];

    byte_mux_rr_arbiter #(.DW(8), .N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_flat (data_flat),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({out_valid, busy, ack, out_data, out_sel} !== {1'b0, 1'b0, 8'h00, 8'h00, 3'd0}) begin
            n_bad++;
            $display("FAIL reset: valid=%b busy=%b ack=%h data=%h sel=%0d, required 0 0 00 00 0",
                     out_valid, busy, ack, out_data, out_sel);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || ack !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_idle: valid=%b ack=%h, required 0 00", out_valid, ack);
        end
    endtask

    task automatic test_single();
        req = 8'h04;
        out_ready = 1'b1;
        tick();
        $display("xfer single: sel=%0d data=%h ack=%h", out_sel, out_data, ack);
        n_cmp++;
        if ({out_valid, busy, out_sel, out_data, ack} !== {1'b1, 1'b1, 3'd2, 8'hc7, 8'h04}) begin
            n_bad++;
            $display("FAIL single: valid=%b busy=%b sel=%0d data=%h ack=%h, required 1 1 2 c7 04",
                     out_valid, busy, out_sel, out_data, ack);
        end
        req = 8'h00;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || ack !== 8'h00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_drain: valid=%b busy=%b ack=%h, required 0 0 00", out_valid, busy, ack);
        end
    endtask

    task automatic test_all_requesting();
        logic [2:0] exp_sel [9];
        for (int i = 0; i < 8; i++) exp_sel[i] = 3'(i);
        exp_sel[8] = 3'd0;
        do_reset();
        req = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            $display("xfer all[%0d]: sel=%0d data=%h ack=%h valid=%b", i, out_sel, out_data, ack, out_valid);
            n_cmp++;
            if (out_sel !== exp_sel[i] || out_data !== exp_byte[exp_sel[i]] || out_valid !== 1'b1 ||
                ack !== (8'h01 << exp_sel[i])) begin
                n_bad++;
                $display("FAIL all[%0d]: sel=%0d data=%h valid=%b ack=%h, required %0d %h 1 %h",
                         i, out_sel, out_data, out_valid, ack, exp_sel[i], exp_byte[exp_sel[i]],
                         8'h01 << exp_sel[i]);
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 8'h03;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            $display("xfer bp[%0d]: sel=%0d data=%h ack=%h", i, out_sel, out_data, ack);
            n_cmp++;
            if (out_sel !== 3'd0 || out_data !== 8'ha5 || out_valid !== 1'b1 ||
                ack !== ((i == 0) ? 8'h01 : 8'h00)) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: sel=%0d data=%h valid=%b ack=%h, required 0 a5 1 %h",
                         i, out_sel, out_data, out_valid, ack, (i == 0) ? 8'h01 : 8'h00);
            end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_sel !== 3'd1 || out_data !== 8'hb8 || out_valid !== 1'b1 || ack !== 8'h02) begin
            n_bad++;
            $display("FAIL bp_release: sel=%0d data=%h valid=%b ack=%h, required 1 b8 1 02",
                     out_sel, out_data, out_valid, ack);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_wrap();
        req = 8'h80;
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_sel !== 3'd7 || out_data !== 8'hd2 || ack !== 8'h80) begin
            n_bad++;
            $display("FAIL wrap_7: sel=%0d data=%h ack=%h, required 7 d2 80", out_sel, out_data, ack);
        end
        req = 8'h81;
        tick();
        n_cmp++;
        if (out_sel !== 3'd0 || out_data !== 8'ha5 || ack !== 8'h01 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_0: sel=%0d data=%h ack=%h valid=%b, required 0 a5 01 1",
                     out_sel, out_data, ack, out_valid);
        end
        tick();
        n_cmp++;
        if (out_sel !== 3'd7 || out_data !== 8'hd2 || ack !== 8'h80) begin
            n_bad++;
            $display("FAIL wrap_back: sel=%0d data=%h ack=%h, required 7 d2 80", out_sel, out_data, ack);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_no_double();
        logic prev_ack;
        logic [7:0] exp_ack;
        prev_ack = 1'b0;
        req = 8'h20;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_ack = (i % 2 == 0) ? 8'h20 : 8'h00;
            $display("xfer nodbl[%0d]: ack=%h valid=%b", i, ack, out_valid);
            n_cmp++;
            if (ack !== exp_ack || out_valid !== exp_ack[5] || (prev_ack && (ack != 8'h00))) begin
                n_bad++;
                $display("FAIL no_double[%0d]: ack=%h valid=%b, required %h %b",
                         i, ack, out_valid, exp_ack, exp_ack[5]);
            end
            prev_ack = (ack != 8'h00);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_async_reset();
        req = 8'hFF;
        out_ready = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_pre: valid=%b, required 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || ack !== 8'h00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_now: valid=%b ack=%h busy=%b, required 0 00 0", out_valid, ack, busy);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_sel !== 3'd0 || out_data !== 8'ha5 || ack !== 8'h01 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL arst_first: sel=%0d data=%h ack=%h valid=%b, required 0 a5 01 1",
                     out_sel, out_data, ack, out_valid);
        end
        tick();
        n_cmp++;
        if (out_sel !== 3'd1 || out_data !== 8'hb8 || ack !== 8'h02) begin
            n_bad++;
            $display("FAIL arst_second: sel=%0d data=%h ack=%h, required 1 b8 02", out_sel, out_data, ack);
        end
        req = 8'h00;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_byte[0] = 8'ha5; exp_byte[1] = 8'hb8; exp_byte[2] = 8'hc7; exp_byte[3] = 8'hd2;
        exp_byte[4] = 8'ha5; exp_byte[5] = 8'hb8; exp_byte[6] = 8'hc7; exp_byte[7] = 8'hd2;
        data_flat = 64'hd2c7b8a5_d2c7b8a5;
        rst_n = 1'b0;
        req = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_all_requesting();
        test_backpressure();
        test_wrap();
        test_no_double();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

endmodule
